// File: rtl/game_tick_gen.sv
// game_tick_gen: turns one bit of the free-running divided-clock bus into
// single-cycle game-update enables, with optional difficulty ramp.
// Optional feature macro: GAME_TICK_LEVEL_RAMP_EN. When it is defined, the
// level rises every TICKS_PER_LEVEL ticks up to MAX_LEVEL, and each level
// step selects the next-faster counter bit. When it is undefined, the level
// stays at 0 and the tap stays at BASE_TAP.
module game_tick_gen #(
   parameter int unsigned BASE_TAP        = 22,
   parameter int unsigned MAX_LEVEL       = 4,
   parameter int unsigned TICKS_PER_LEVEL = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] divided_clocks,
   input  logic        run,
   input  logic        pause,
   output logic        tick,
   output logic        level_up,
   output logic [2:0]  level,
   output logic [4:0]  tap,
   output logic [15:0] tick_count
);

   typedef enum logic [1:0] {StIdle, StRun, StPaused} state_t;

   state_t      state_q, state_d;
   logic        prev_q;
   logic        suppress_q, suppress_d;
   logic        tick_q, tick_d;
   logic [15:0] tick_count_q, tick_count_d;
   logic        sel_bit;
   logic        tick_edge;
   logic        restart;

   // Reject parameter sets outside the supported ranges at elaboration.
   if (MAX_LEVEL > 7 || BASE_TAP < MAX_LEVEL || BASE_TAP > 31 || TICKS_PER_LEVEL < 2)
   begin : g_param_check
      $error("game_tick_gen: parameter out of range");
   end

   // prev always follows the currently selected bit, so a change of tap
   // leaves prev stale for exactly one cycle; suppress covers that cycle.
   assign sel_bit   = divided_clocks[tap];
   assign tick_edge = sel_bit & ~prev_q & ~suppress_q;
   assign restart   = ~run | (state_q == StIdle);

   assign tick       = tick_q;
   assign tick_count = tick_count_q;

   // Next-state logic; run low overrides everything, including pause.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (run)    state_d = StRun;
         StRun:    if (pause)  state_d = StPaused;
         StPaused: if (!pause) state_d = StRun;
         default:  state_d = StIdle;
      endcase
      if (!run) state_d = StIdle;
   end

   // Tick only from RUN and only when run and pause allow it this cycle.
   // tick_count follows emitted ticks and clears while idle or stopping.
   always_comb begin
      tick_d       = (state_q == StRun) & run & ~pause & tick_edge;
      tick_count_d = tick_count_q;
      if (restart) begin
         tick_count_d = '0;
      end else if (tick_q) begin
         tick_count_d = tick_count_q + 16'd1;
      end
   end

   // Core state registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= StIdle;
         prev_q       <= 1'b0;
         suppress_q   <= 1'b1;
         tick_q       <= 1'b0;
         tick_count_q <= '0;
      end else begin
         state_q      <= state_d;
         prev_q       <= sel_bit;
         suppress_q   <= suppress_d;
         tick_q       <= tick_d;
         tick_count_q <= tick_count_d;
      end
   end

`ifdef GAME_TICK_LEVEL_RAMP_EN
   localparam int unsigned LvlCntW = $clog2(TICKS_PER_LEVEL);

   logic [LvlCntW-1:0] lvl_cnt_q, lvl_cnt_d;
   logic [2:0]         level_q, level_d;
   logic               level_up_q;
   logic               advance;

   assign level    = level_q;
   assign level_up = level_up_q;
   assign tap      = 5'(BASE_TAP) - 5'(level_q);

   // Count ticks at the current level and step up once the quota is met.
   // At MAX_LEVEL the counter is never incremented and so stays at 0.
   always_comb begin
      level_d   = level_q;
      lvl_cnt_d = lvl_cnt_q;
      advance   = 1'b0;
      if (restart) begin
         level_d   = '0;
         lvl_cnt_d = '0;
      end else if (tick_q && (level_q < 3'(MAX_LEVEL))) begin
         if (lvl_cnt_q == LvlCntW'(TICKS_PER_LEVEL - 1)) begin
            advance   = 1'b1;
            level_d   = level_q + 3'd1;
            lvl_cnt_d = '0;
         end else begin
            lvl_cnt_d = lvl_cnt_q + 1'b1;
         end
      end
      suppress_d = advance;
   end

   // Level registers; level_up is a one-cycle echo of the advance.
   always_ff @(posedge clock) begin
      if (reset) begin
         level_q    <= '0;
         lvl_cnt_q  <= '0;
         level_up_q <= 1'b0;
      end else begin
         level_q    <= level_d;
         lvl_cnt_q  <= lvl_cnt_d;
         level_up_q <= advance;
      end
   end
`else
   assign level      = 3'd0;
   assign level_up   = 1'b0;
   assign tap        = 5'(BASE_TAP);
   assign suppress_d = 1'b0;
`endif

endmodule

// File: tb/tb_game_tick_gen.sv
// Self-checking bench for game_tick_gen: random run/pause/reset stimulus,
// a rule-level reference model feeding an expected-response queue, and a
// monitor that pops and compares every cycle after the clock edge.
module tb_game_tick_gen;

   localparam int unsigned BaseTap   = 3;
   localparam int unsigned MaxLevel  = 2;
   localparam int unsigned Tpl       = 4;
   localparam int unsigned NumCycles = 6000;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] divided_clocks;
   logic        run;
   logic        pause;
   logic        tick;
   logic        level_up;
   logic [2:0]  level;
   logic [4:0]  tap;
   logic [15:0] tick_count;

   always #5 clock = ~clock;

   game_tick_gen #(
      .BASE_TAP        (BaseTap),
      .MAX_LEVEL       (MaxLevel),
      .TICKS_PER_LEVEL (Tpl)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .divided_clocks (divided_clocks),
      .run            (run),
      .pause          (pause),
      .tick           (tick),
      .level_up       (level_up),
      .level          (level),
      .tap            (tap),
      .tick_count     (tick_count)
   );

   typedef struct packed {
      logic        tick;
      logic        level_up;
      logic [2:0]  level;
      logic [4:0]  tap;
      logic [15:0] tick_count;
   } exp_t;

   exp_t exp_q[$];

   int unsigned checks = 0;
   int unsigned passed = 0;
   bit          armed  = 1'b0;
   bit          done   = 1'b0;

   // Reference model: 0 = idle, 1 = running, 2 = paused.
   int          m_mode      = 0;
   int          m_level     = 0;
   int          m_lvl_ticks = 0;
   int unsigned m_count     = 0;
   bit          m_tick      = 1'b0;
   bit          m_lu        = 1'b0;
   bit          m_supp      = 1'b1;

   function automatic bit rises(input logic [31:0] c, input int k);
      logic [31:0] cm1;
      cm1 = c - 32'd1;
      return c[k] && !cm1[k];
   endfunction

   // Advance the model by one clock given the inputs held across that edge.
   task automatic model_step(input bit rst, input bit r, input bit p, input logic [31:0] c);
      bit new_tick;
      int new_mode;
      if (rst) begin
         m_mode = 0; m_level = 0; m_lvl_ticks = 0; m_count = 0;
         m_tick = 1'b0; m_lu = 1'b0; m_supp = 1'b1;
         return;
      end
      new_tick = (m_mode == 1) && r && !p && !m_supp && rises(c, BaseTap - m_level);
      m_lu   = 1'b0;
      m_supp = 1'b0;
      if (!r || m_mode == 0) begin
         m_level = 0; m_lvl_ticks = 0; m_count = 0;
      end else if (m_tick) begin
         m_count = (m_count + 1) % 65536;
`ifdef GAME_TICK_LEVEL_RAMP_EN
         if (m_level < int'(MaxLevel)) begin
            m_lvl_ticks++;
            if (m_lvl_ticks == int'(Tpl)) begin
               m_lvl_ticks = 0;
               m_level++;
               m_lu   = 1'b1;
               m_supp = 1'b1;
            end
         end
`endif
      end
      if (!r)                  new_mode = 0;
      else if (m_mode == 0)    new_mode = 1;
      else if (m_mode == 1)    new_mode = p ? 2 : 1;
      else                     new_mode = p ? 2 : 1;
      m_mode = new_mode;
      m_tick = new_tick;
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
   endtask

   // Stimulus and expected-response producer.
   initial begin
      logic [31:0] cnt;
      int          stop_left;
      int          pause_left;
      bit          want_edge_rst;
      exp_t        e;
      cnt = '0; stop_left = 0; pause_left = 0; want_edge_rst = 1'b0;
      reset = 1'b1; run = 1'b0; pause = 1'b0; divided_clocks = '0;
      for (int cyc = 0; cyc < int'(NumCycles); cyc++) begin
         @(negedge clock);
         divided_clocks = cnt;
         if (cyc == 3000) want_edge_rst = 1'b1;
         if (cyc < 3) begin
            reset = 1'b1; run = 1'b0; pause = 1'b0;
         end else begin
            reset = ($urandom_range(0, 2999) == 0);
            // Force one reset that lands on a live edge while running.
            if (want_edge_rst && m_mode == 1 && !m_supp && rises(cnt, BaseTap - m_level)) begin
               reset = 1'b1;
               want_edge_rst = 1'b0;
            end
            if (stop_left > 0) begin
               run = 1'b0;
               stop_left--;
            end else begin
               run = 1'b1;
               if ($urandom_range(0, 499) == 0) stop_left = $urandom_range(1, 3);
            end
            if (pause_left > 0) begin
               pause = 1'b1;
               pause_left--;
            end else begin
               pause = 1'b0;
               if ($urandom_range(0, 199) == 0) pause_left = $urandom_range(1, 60);
            end
         end
         model_step(reset, run, pause, cnt);
         e.tick       = m_tick;
         e.level_up   = m_lu;
         e.level      = 3'(m_level);
         e.tap        = 5'(BaseTap - m_level);
         e.tick_count = 16'(m_count);
         exp_q.push_back(e);
         armed = 1'b1;
         cnt   = cnt + 32'd1;
      end
      @(posedge clock);
      #2;
      done = 1'b1;
      #20;
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Monitor: one expected record per clock edge once stimulus has begun.
   initial begin
      exp_t e;
      while (!done) begin
         @(posedge clock);
         #1;
         if (done) break;
         if (armed) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL scoreboard_empty at %0t: got no expected entry, required one", $time);
            end else begin
               e = exp_q.pop_front();
               check("tick",       int'(tick),       int'(e.tick));
               check("level_up",   int'(level_up),   int'(e.level_up));
               check("level",      int'(level),      int'(e.level));
               check("tap",        int'(tap),        int'(e.tap));
               check("tick_count", int'(tick_count), int'(e.tick_count));
            end
         end
      end
   end

endmodule
